// File: rtl/ddr3_fsm_pkg.sv
// Shared definitions for the DDR3 frame-buffer read and write FSMs.
// Word addresses are in 32-byte units throughout.
package ddr3_fsm_pkg;

  localparam int DDR3_WORD_AW      = 27;
  localparam int QUARTER_WORDS_DEF = 'h5A00;
  localparam int WORD_CNT_W        = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WRITE,
    ST_DRAIN,
    ST_PUBLISH
  } wr_state_t;

  function automatic int frame_words(input int quarter_words, input int quarters);
    return quarter_words * quarters;
  endfunction

endpackage

// File: rtl/ddr3_writer_fsm_if.sv
// Pixel stream in, DDR3 write commands out, and the completed-frame pointer.
// The master side is the writer FSM; the slave side is its surroundings.
interface ddr3_writer_fsm_if;
  import ddr3_fsm_pkg::*;

  logic [255:0]              pix_data;
  logic                      pix_valid;
  logic                      pix_ready;
  logic [DDR3_WORD_AW-1:0]   write_addr_data;
  logic [255:0]              write_data;
  logic                      write_valid;
  logic                      write_ready;
  logic [1:0]                ptr_data;
  logic                      ptr_valid;
  logic                      ptr_ready;

  modport master (
    input  pix_data, pix_valid, write_ready, ptr_ready,
    output pix_ready, write_addr_data, write_data, write_valid, ptr_data, ptr_valid
  );

  modport slave (
    output pix_data, pix_valid, write_ready, ptr_ready,
    input  pix_ready, write_addr_data, write_data, write_valid, ptr_data, ptr_valid
  );

endinterface

// File: rtl/ddr3_writer_fsm.sv
// Write-side address generator for one camera's DDR3 frame buffer: turns a
// pixel-word stream into word-addressed writes and publishes a frame counter.
module ddr3_writer_fsm
  import ddr3_fsm_pkg::*;
#(
  parameter int QUARTER_WORDS = QUARTER_WORDS_DEF,
  parameter int QUARTERS      = 4,
  parameter int SLOT_MODE     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              cam_start,
  input  logic                     sof,
  ddr3_writer_fsm_if.master        bus,
  output logic [7:0]               frame_drop_cnt,
  output logic                     busy
);

  localparam int FRAME_WORDS_P = frame_words(QUARTER_WORDS, QUARTERS);
  localparam logic [WORD_CNT_W-1:0]   LAST_WORD     = WORD_CNT_W'(FRAME_WORDS_P - 1);
  localparam logic [DDR3_WORD_AW-1:0] FRAME_WORDS_A = DDR3_WORD_AW'(FRAME_WORDS_P);

  wr_state_t                 state_q, state_d;
  logic [DDR3_WORD_AW-1:0]   frame_base_q, frame_base_d;
  logic [DDR3_WORD_AW-1:0]   write_addr_q, write_addr_d;
  logic [255:0]              write_data_q, write_data_d;
  logic                      write_valid_q, write_valid_d;
  logic [WORD_CNT_W-1:0]     word_cnt_q, word_cnt_d;
  logic [1:0]                ptr_data_q, ptr_data_d;
  logic                      ptr_valid_q, ptr_valid_d;
  logic [7:0]                drop_cnt_q, drop_cnt_d;
  logic                      sof_pending_q, sof_pending_d;

  logic                      pix_ready_c;
  logic                      accept;
  logic [1:0]                next_slot;
  logic [DDR3_WORD_AW-1:0]   slot_offset;
  logic [7:0]                drop_cnt_inc;
  logic                      unused_cam_lsb;

  assign unused_cam_lsb = ^cam_start[4:0];

  // Single output register with no skid: a new word can only enter when the
  // current command is absent or leaving this cycle.
  always_comb begin
    pix_ready_c = 1'b0;
    unique case (state_q)
      ST_IDLE:  pix_ready_c = 1'b1;
      ST_WRITE: pix_ready_c = !write_valid_q || bus.write_ready;
      default:  pix_ready_c = 1'b0;
    endcase
  end

  assign accept = bus.pix_valid && pix_ready_c;

  always_comb begin
    state_d       = state_q;
    frame_base_d  = frame_base_q;
    write_addr_d  = write_addr_q;
    write_data_d  = write_data_q;
    write_valid_d = write_valid_q;
    word_cnt_d    = word_cnt_q;
    ptr_data_d    = ptr_data_q;
    ptr_valid_d   = ptr_valid_q;
    drop_cnt_d    = drop_cnt_q;
    sof_pending_d = sof_pending_q;

    next_slot    = ptr_data_q + 2'd1;
    slot_offset  = (SLOT_MODE != 0) ?
                   {{(DDR3_WORD_AW-2){1'b0}}, next_slot} * FRAME_WORDS_A : '0;
    drop_cnt_inc = (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;

    if (write_valid_q && bus.write_ready) write_valid_d = 1'b0;
    if (bus.ptr_ready)                    ptr_valid_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (sof || sof_pending_q) begin
          state_d       = ST_ARM;
          sof_pending_d = 1'b0;
        end
      end

      ST_ARM: begin
        frame_base_d = cam_start[31:5] + slot_offset;
        word_cnt_d   = '0;
        state_d      = ST_WRITE;
      end

      ST_WRITE: begin
        if (accept) begin
          write_addr_d  = frame_base_q + {{(DDR3_WORD_AW-WORD_CNT_W){1'b0}}, word_cnt_q};
          write_data_d  = bus.pix_data;
          write_valid_d = 1'b1;
          word_cnt_d    = word_cnt_q + WORD_CNT_W'(1);
          if (word_cnt_q == LAST_WORD) state_d = ST_DRAIN;
        end
        // Abort wins over a last-word transition; a registered write still drains.
        if (sof) begin
          drop_cnt_d = drop_cnt_inc;
          state_d    = ST_ARM;
        end
      end

      ST_DRAIN: begin
        if (!write_valid_q || bus.write_ready) state_d = ST_PUBLISH;
        if (sof) sof_pending_d = 1'b1;
      end

      ST_PUBLISH: begin
        ptr_data_d  = ptr_data_q + 2'd1;
        ptr_valid_d = 1'b1;
        if (ptr_valid_q && !bus.ptr_ready) drop_cnt_d = drop_cnt_inc;
        if (sof) sof_pending_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      frame_base_q  <= '0;
      write_addr_q  <= '0;
      write_data_q  <= '0;
      write_valid_q <= 1'b0;
      word_cnt_q    <= '0;
      ptr_data_q    <= 2'd0;
      ptr_valid_q   <= 1'b0;
      drop_cnt_q    <= 8'd0;
      sof_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_base_q  <= frame_base_d;
      write_addr_q  <= write_addr_d;
      write_data_q  <= write_data_d;
      write_valid_q <= write_valid_d;
      word_cnt_q    <= word_cnt_d;
      ptr_data_q    <= ptr_data_d;
      ptr_valid_q   <= ptr_valid_d;
      drop_cnt_q    <= drop_cnt_d;
      sof_pending_q <= sof_pending_d;
    end
  end

  assign bus.pix_ready       = pix_ready_c;
  assign bus.write_addr_data = write_addr_q;
  assign bus.write_data      = write_data_q;
  assign bus.write_valid     = write_valid_q;
  assign bus.ptr_data        = ptr_data_q;
  assign bus.ptr_valid       = ptr_valid_q;
  assign frame_drop_cnt      = drop_cnt_q;
  assign busy                = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ddr3_writer_fsm.sv
// Bench for ddr3_writer_fsm: a fixed-base and a slot-mode instance share one
// stimulus stream and are each scored against a frame-level reference model.
module tb_ddr3_writer_fsm;
  import ddr3_fsm_pkg::*;

  localparam int FW = 16;

  typedef struct packed {
    logic [26:0]  addr;
    logic [255:0] data;
    logic         last;
  } exp_t;

  logic         clk;
  logic         reset;
  logic [31:0]  cam_start;
  logic         sof;
  logic [255:0] pix_data;
  logic         pix_valid;
  logic         write_ready;
  logic         ptr_ready;
  logic [7:0]   drop0, drop1;
  logic         busy0, busy1;

  ddr3_writer_fsm_if bus0 ();
  ddr3_writer_fsm_if bus1 ();

  assign bus0.pix_data = pix_data;   assign bus1.pix_data = pix_data;
  assign bus0.pix_valid = pix_valid; assign bus1.pix_valid = pix_valid;
  assign bus0.write_ready = write_ready; assign bus1.write_ready = write_ready;
  assign bus0.ptr_ready = ptr_ready; assign bus1.ptr_ready = ptr_ready;

  ddr3_writer_fsm #(.QUARTER_WORDS(4), .QUARTERS(4), .SLOT_MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .cam_start(cam_start), .sof(sof),
    .bus(bus0), .frame_drop_cnt(drop0), .busy(busy0));

  ddr3_writer_fsm #(.QUARTER_WORDS(4), .QUARTERS(4), .SLOT_MODE(1)) u_dut1 (
    .clk(clk), .reset(reset), .cam_start(cam_start), .sof(sof),
    .bus(bus1), .frame_drop_cnt(drop1), .busy(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int wr_mode;   // 0: ready high, 1: toggle, 2: random, 3: held low
  int vmode;     // 0: pix_valid always high, 1: random gaps
  logic last_acc;

  exp_t        q0[$], q1[$];
  logic [26:0] mbase[2];
  int          widx[2];
  logic [1:0]  mptr[2];
  logic        munc[2];
  int          mdrop[2];
  int          pub_cd[2];
  logic        active[2];

  task automatic chk(input string tag, input int i, input logic [255:0] obs, input logic [255:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, want);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [26:0] frame_base_for(input int i);
    int unsigned off;
    off = (i == 1) ? ((int'(mptr[i]) + 1) % 4) * FW : 0;
    return 27'((cam_start >> 5) + off);
  endfunction

  task automatic model_reset();
    q0.delete(); q1.delete();
    for (int i = 0; i < 2; i++) begin
      mbase[i] = '0; widx[i] = 0; mptr[i] = 2'd0; munc[i] = 1'b0;
      mdrop[i] = 0; pub_cd[i] = 0; active[i] = 1'b0;
    end
  endtask

  // Checks one instance's outputs for the current cycle, then advances the model
  // by what the inputs and handshakes of this cycle imply.
  task automatic model_cycle(input int i, input logic pr, input logic wv, input logic [26:0] wa,
                             input logic [255:0] wd, input logic pv, input logic [1:0] pd,
                             input logic [7:0] dc, input logic bz, output logic acc);
    exp_t head;
    exp_t e;
    int   qs;
    qs   = (i == 0) ? q0.size() : q1.size();
    head = '0;
    if (qs != 0) head = (i == 0) ? q0[0] : q1[0];

    chk("write_valid", i, wv, qs != 0);
    if (qs != 0) begin
      chk("write_addr", i, wa, head.addr);
      chk("write_data", i, wd, head.data);
    end
    if (qs != 0 && !write_ready) chk("pix_ready_stall", i, pr, 1'b0);
    if (!active[i] && qs == 0 && pub_cd[i] == 0) chk("pix_ready_idle", i, pr, 1'b1);
    chk("busy", i, bz, active[i] || qs != 0 || pub_cd[i] != 0);
    chk("ptr_valid", i, pv, munc[i]);
    chk("ptr_data", i, pd, mptr[i]);
    chk("drop_cnt", i, dc, mdrop[i]);

    if (pub_cd[i] == 1) begin
      if (munc[i] && !ptr_ready && mdrop[i] < 255) mdrop[i]++;
      mptr[i] = mptr[i] + 2'd1;
      munc[i] = 1'b1;
    end else if (ptr_ready) begin
      munc[i] = 1'b0;
    end
    if (pub_cd[i] > 0) pub_cd[i]--;

    if (qs != 0 && write_ready) begin
      if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      if (head.last) pub_cd[i] = 1;
    end

    if (sof) begin
      if (active[i] && mdrop[i] < 255) mdrop[i]++;
      mbase[i]  = frame_base_for(i);
      widx[i]   = 0;
      active[i] = 1'b1;
    end

    acc = pix_valid && pr;
    if (acc && active[i]) begin
      e.addr = mbase[i] + 27'(widx[i]);
      e.data = pix_data;
      e.last = (widx[i] == FW - 1);
      if (i == 0) q0.push_back(e); else q1.push_back(e);
      widx[i]++;
      if (widx[i] == FW) active[i] = 1'b0;
    end
  endtask

  task automatic cycle();
    logic a0, a1;
    @(negedge clk);
    model_cycle(0, bus0.pix_ready, bus0.write_valid, bus0.write_addr_data, bus0.write_data,
                bus0.ptr_valid, bus0.ptr_data, drop0, busy0, a0);
    model_cycle(1, bus1.pix_ready, bus1.write_valid, bus1.write_addr_data, bus1.write_data,
                bus1.ptr_valid, bus1.ptr_data, drop1, busy1, a1);
    last_acc = a0;
    @(posedge clk);
    #1;
    case (wr_mode)
      0:       write_ready = 1'b1;
      1:       write_ready = !write_ready;
      2:       write_ready = 1'($urandom_range(0, 1));
      default: write_ready = 1'b0;
    endcase
  endtask

  task automatic pulse_sof();
    sof = 1'b1; pix_valid = 1'b0;
    cycle();
    sof = 1'b0;
  endtask

  task automatic pulse_ptr();
    ptr_ready = 1'b1;
    cycle();
    ptr_ready = 1'b0;
    cycle();
  endtask

  task automatic send_words(input int n);
    int sent;
    int guard;
    sent = 0; guard = 0;
    pix_data = rand256();
    while (sent < n && guard < 4000) begin
      pix_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      cycle();
      if (last_acc) begin
        sent++;
        pix_data = rand256();
      end
      guard++;
    end
    pix_valid = 1'b0;
    chk("words_sent", 0, sent, n);
  endtask

  task automatic wait_idle();
    int guard;
    logic done;
    guard = 0; done = 1'b0;
    while (!done && guard < 500) begin
      cycle();
      done = (q0.size() == 0) && (q1.size() == 0) && (pub_cd[0] == 0) && (pub_cd[1] == 0)
             && !active[0] && !active[1];
      guard++;
    end
    chk("idle_reached", 0, done, 1'b1);
    cycle();
    chk("busy_idle", 0, busy0, 1'b0);
    chk("busy_idle", 1, busy1, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sof = 1'b0; pix_valid = 1'b0; pix_data = '0;
    write_ready = 1'b1; ptr_ready = 1'b0; cam_start = 32'h1000_0000;
    wr_mode = 0; vmode = 0; last_acc = 1'b0;
    model_reset();

    #3;
    chk("rst_write_valid", 0, bus0.write_valid, 1'b0);
    chk("rst_ptr_valid", 0, bus0.ptr_valid, 1'b0);
    chk("rst_ptr_data", 0, bus0.ptr_data, 2'd0);
    chk("rst_drop", 0, drop0, 8'd0);
    chk("rst_busy", 1, busy1, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Words offered while idle are discarded
    pix_valid = 1'b1; pix_data = rand256();
    repeat (3) cycle();
    pix_valid = 1'b0;

    // Full frame, controller always ready
    pulse_sof();
    send_words(FW);
    wait_idle();
    chk("t1_ptr_data", 0, bus0.ptr_data, 2'd1);
    repeat (3) cycle();
    pulse_ptr();
    chk("t1_ptr_cleared", 0, bus0.ptr_valid, 1'b0);

    // Controller ready toggling every cycle
    wr_mode = 1;
    pulse_sof();
    send_words(FW);
    wait_idle();
    pulse_ptr();

    // Abort after 7 words, then a full frame restarts at word 0
    wr_mode = 0;
    pulse_sof();
    send_words(7);
    pulse_sof();
    cycle();
    chk("t3_drop", 0, drop0, 8'd1);
    chk("t3_ptr_kept", 0, bus0.ptr_data, 2'd2);
    send_words(FW);
    wait_idle();
    chk("t3_ptr_data", 0, bus0.ptr_data, 2'd3);
    pulse_ptr();

    // Four frames with random gaps and back-pressure; base low bits must be ignored
    wr_mode = 2; vmode = 1; cam_start = 32'h0ABC_DE1F;
    for (int f = 0; f < 4; f++) begin
      pulse_sof();
      send_words(FW);
      wait_idle();
      pulse_ptr();
    end

    // Two frames without the reader consuming; base near the top of the address space
    cam_start = 32'hFFFF_FFE0;
    for (int f = 0; f < 2; f++) begin
      pulse_sof();
      send_words(FW);
      wait_idle();
    end
    chk("t5_ptr_valid", 0, bus0.ptr_valid, 1'b1);
    chk("t5_ptr_data", 0, bus0.ptr_data, 2'd1);
    chk("t5_drop", 1, drop1, 8'd2);
    pulse_ptr();

    // Repeated aborts drive the drop counter into saturation
    for (int k = 0; k < 270; k++) begin
      sof = 1'b1;
      cycle();
      sof = 1'b0;
      cycle();
    end
    chk("sat_drop", 0, drop0, 8'd255);
    send_words(FW);
    wait_idle();

    // Reset mid-frame with a stalled command in flight
    wr_mode = 0; vmode = 0; cam_start = 32'h1000_0000;
    pulse_sof();
    send_words(5);
    wr_mode = 3; write_ready = 1'b0;
    cycle();
    reset = 1'b1;
    #1;
    chk("midrst_write_valid", 0, bus0.write_valid, 1'b0);
    chk("midrst_ptr_valid", 0, bus0.ptr_valid, 1'b0);
    chk("midrst_busy", 0, busy0, 1'b0);
    chk("midrst_write_valid", 1, bus1.write_valid, 1'b0);
    chk("midrst_drop", 1, drop1, 8'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    wr_mode = 2; vmode = 1;
    pulse_sof();
    send_words(FW);
    wait_idle();
    chk("post_rst_ptr", 1, bus1.ptr_data, 2'd1);
    pulse_ptr();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
